// File: rtl/cpu_trace_spi_ctrl_pkg.sv
// Shared constants, FSM encoding and response helpers for the CPU trace SPI controller.
package cpu_trace_spi_ctrl_pkg;

  localparam logic [7:0] CMD_STATUS = 8'h01;
  localparam logic [7:0] CMD_READ   = 8'h02;
  localparam logic [7:0] CMD_CLEAR  = 8'h03;

  localparam logic [7:0] CLEAR_ACK  = 8'hA5;
  localparam logic [7:0] BAD_CMD    = 8'hFF;
  localparam logic [7:0] EMPTY_BYTE = 8'h00;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_CMD  = 2'd1,
    S_RESP = 2'd2
  } spi_state_t;

  function automatic logic [7:0] f_status_byte(input logic i_ovf, input logic [4:0] i_cnt);
    return {i_ovf, 2'b00, i_cnt};
  endfunction

endpackage

// File: rtl/cpu_trace_spi_ctrl_trace_fifo.sv
// Show-ahead synchronous byte FIFO; flush overrides push and pop, a push into a
// full FIFO is accepted only when a pop frees a slot in the same cycle.
module trace_fifo #(
  parameter int DEPTH_LOG2 = 4
) (
  input  logic                  i_clk,
  input  logic                  i_reset_n,
  input  logic                  i_push,
  input  logic                  i_pop,
  input  logic                  i_flush,
  input  logic [7:0]            i_din,
  output logic [7:0]            o_dout,
  output logic [DEPTH_LOG2:0]   o_count,
  output logic                  o_full,
  output logic                  o_empty
);

  localparam int DEPTH = 2 ** DEPTH_LOG2;
  localparam logic [DEPTH_LOG2:0] FULL_CNT = {1'b1, {DEPTH_LOG2{1'b0}}};
  localparam logic [DEPTH_LOG2:0] ZERO_CNT = {(DEPTH_LOG2 + 1){1'b0}};

  logic [7:0]            r_mem [DEPTH];
  logic [DEPTH_LOG2-1:0] r_wptr;
  logic [DEPTH_LOG2-1:0] r_rptr;
  logic [DEPTH_LOG2:0]   r_count;
  logic                  w_do_pop;
  logic                  w_do_push;

  assign o_full    = (r_count == FULL_CNT);
  assign o_empty   = (r_count == ZERO_CNT);
  assign o_count   = r_count;
  assign o_dout    = r_mem[r_rptr];
  assign w_do_pop  = i_pop && !o_empty;
  assign w_do_push = i_push && (!o_full || w_do_pop);

  // Storage array write port
  always_ff @(posedge i_clk) begin
    if (!i_reset_n) begin
      for (int k = 0; k < DEPTH; k++) begin
        r_mem[k] <= 8'h00;
      end
    end else if (w_do_push && !i_flush) begin
      r_mem[r_wptr] <= i_din;
    end
  end

  // Pointers and occupancy
  always_ff @(posedge i_clk) begin
    if (!i_reset_n) begin
      r_wptr  <= {DEPTH_LOG2{1'b0}};
      r_rptr  <= {DEPTH_LOG2{1'b0}};
      r_count <= ZERO_CNT;
    end else if (i_flush) begin
      r_wptr  <= {DEPTH_LOG2{1'b0}};
      r_rptr  <= {DEPTH_LOG2{1'b0}};
      r_count <= ZERO_CNT;
    end else begin
      if (w_do_push) begin
        r_wptr <= r_wptr + 1'b1;
      end
      if (w_do_pop) begin
        r_rptr <= r_rptr + 1'b1;
      end
      case ({w_do_push, w_do_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

endmodule

// File: rtl/cpu_trace_spi_ctrl.sv
// Buffers captured CPU debug instruction bytes and serves them to an external
// SPI mode-0 master through a one-command-per-chip-select protocol.
module cpu_trace_spi_ctrl
  import cpu_trace_spi_ctrl_pkg::*;
#(
  parameter int DEPTH_LOG2  = 4,
  parameter int SYNC_STAGES = 2
) (
  input  logic                  i_clk,
  input  logic                  i_reset_n,
  input  logic [7:0]            i_instruction,
  input  logic                  i_capturebyte,
  input  logic                  i_spi_clk,
  input  logic                  i_csn,
  input  logic                  i_mosi,
  output logic                  o_miso,
  output logic [DEPTH_LOG2:0]   o_fifo_count,
  output logic                  o_overflow
);

  // Synchroniser bit order is {capture, csn, mosi, sck}; csn idles high.
  localparam logic [3:0] SYNC_RST = 4'b0100;

  logic [SYNC_STAGES-1:0][3:0] r_sync;
  logic [2:0]                  r_prev;
  logic [3:0]                  w_async;
  logic [3:0]                  w_sync;
  logic                        w_mosi_s;
  logic                        w_sck_rise;
  logic                        w_sck_fall;
  logic                        w_csn_rise;
  logic                        w_csn_fall;
  logic                        w_cap_rise;

  spi_state_t                  r_state;
  spi_state_t                  w_state_nxt;
  logic [2:0]                  r_bit_cnt;
  logic [2:0]                  w_bit_cnt_nxt;
  logic [7:0]                  r_shift_in;
  logic [7:0]                  w_shift_nxt;
  logic [7:0]                  r_cmd;
  logic [7:0]                  w_cmd_nxt;
  logic [7:0]                  r_tx;
  logic [7:0]                  w_tx_nxt;
  logic                        r_rise_seen;
  logic                        w_rise_seen_nxt;
  logic                        r_miso;
  logic                        w_miso_nxt;
  logic                        r_ovf;
  logic                        w_ovf_nxt;

  logic [7:0]                  w_cmd_byte;
  logic [7:0]                  w_load_cmd;
  logic                        w_load;
  logic                        w_decode;
  logic                        w_pop;
  logic                        w_flush;

  logic [7:0]                  w_dout;
  logic [DEPTH_LOG2:0]         w_count;
  logic                        w_full;
  logic                        w_empty;
  logic [4:0]                  w_cnt5;

  assign w_async    = {i_capturebyte, i_csn, i_mosi, i_spi_clk};
  assign w_sync     = r_sync[SYNC_STAGES-1];
  assign w_mosi_s   = w_sync[1];
  assign w_sck_rise =  w_sync[0] && !r_prev[0];
  assign w_sck_fall = !w_sync[0] &&  r_prev[0];
  assign w_csn_rise =  w_sync[2] && !r_prev[1];
  assign w_csn_fall = !w_sync[2] &&  r_prev[1];
  assign w_cap_rise =  w_sync[3] && !r_prev[2];
  assign w_cmd_byte = {r_shift_in[6:0], w_mosi_s};

  generate
    if (DEPTH_LOG2 + 1 >= 5) begin : g_cnt_trunc
      assign w_cnt5 = w_count[4:0];
    end else begin : g_cnt_ext
      assign w_cnt5 = {{(4 - DEPTH_LOG2){1'b0}}, w_count};
    end
  endgenerate

  trace_fifo #(
    .DEPTH_LOG2 (DEPTH_LOG2)
  ) u_fifo (
    .i_clk     (i_clk),
    .i_reset_n (i_reset_n),
    .i_push    (w_cap_rise),
    .i_pop     (w_pop),
    .i_flush   (w_flush),
    .i_din     (i_instruction),
    .o_dout    (w_dout),
    .o_count   (w_count),
    .o_full    (w_full),
    .o_empty   (w_empty)
  );

  // Input synchronisers and previous-value flops for edge detection
  always_ff @(posedge i_clk) begin
    if (!i_reset_n) begin
      r_sync <= {SYNC_STAGES{SYNC_RST}};
      r_prev <= 3'b010;
    end else begin
      r_sync <= {r_sync[SYNC_STAGES-2:0], w_async};
      r_prev <= {w_sync[3], w_sync[2], w_sync[0]};
    end
  end

  // SPI protocol state, shift registers, MISO and overflow flag
  always_ff @(posedge i_clk) begin
    if (!i_reset_n) begin
      r_state     <= S_IDLE;
      r_bit_cnt   <= 3'd0;
      r_shift_in  <= 8'h00;
      r_cmd       <= 8'h00;
      r_tx        <= 8'h00;
      r_rise_seen <= 1'b0;
      r_miso      <= 1'b0;
      r_ovf       <= 1'b0;
    end else begin
      r_state     <= w_state_nxt;
      r_bit_cnt   <= w_bit_cnt_nxt;
      r_shift_in  <= w_shift_nxt;
      r_cmd       <= w_cmd_nxt;
      r_tx        <= w_tx_nxt;
      r_rise_seen <= w_rise_seen_nxt;
      r_miso      <= w_miso_nxt;
      r_ovf       <= w_ovf_nxt;
    end
  end

  // Next-state, byte loading and FIFO control
  always_comb begin
    w_state_nxt     = r_state;
    w_bit_cnt_nxt   = r_bit_cnt;
    w_shift_nxt     = r_shift_in;
    w_cmd_nxt       = r_cmd;
    w_tx_nxt        = r_tx;
    w_rise_seen_nxt = r_rise_seen;
    w_load          = 1'b0;
    w_decode        = 1'b0;
    w_load_cmd      = r_cmd;
    w_pop           = 1'b0;
    w_flush         = 1'b0;

    if (w_csn_rise) begin
      w_state_nxt     = S_IDLE;
      w_bit_cnt_nxt   = 3'd0;
      w_shift_nxt     = 8'h00;
      w_tx_nxt        = 8'h00;
      w_rise_seen_nxt = 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_csn_fall) begin
            w_state_nxt   = S_CMD;
            w_bit_cnt_nxt = 3'd0;
            w_shift_nxt   = 8'h00;
          end else begin
            w_state_nxt = S_IDLE;
          end
        end
        S_CMD: begin
          if (w_sck_rise) begin
            w_shift_nxt   = w_cmd_byte;
            w_bit_cnt_nxt = r_bit_cnt + 3'd1;
            if (r_bit_cnt == 3'd7) begin
              w_state_nxt     = S_RESP;
              w_cmd_nxt       = w_cmd_byte;
              w_load_cmd      = w_cmd_byte;
              w_load          = 1'b1;
              w_decode        = 1'b1;
              w_bit_cnt_nxt   = 3'd0;
              w_rise_seen_nxt = 1'b0;
            end else begin
              w_state_nxt = S_CMD;
            end
          end else begin
            w_state_nxt = S_CMD;
          end
        end
        S_RESP: begin
          // Shifts only on a fall that follows a rise in this state, so the
          // trailing fall of the command byte leaves bit 7 on the line.
          if (w_sck_rise) begin
            w_rise_seen_nxt = 1'b1;
            w_bit_cnt_nxt   = r_bit_cnt + 3'd1;
          end else if (w_sck_fall && r_rise_seen) begin
            w_rise_seen_nxt = 1'b0;
            if (r_bit_cnt == 3'd0) begin
              w_load = 1'b1;
            end else begin
              w_tx_nxt = {r_tx[6:0], 1'b0};
            end
          end else begin
            w_state_nxt = S_RESP;
          end
        end
        default: begin
          w_state_nxt = S_IDLE;
        end
      endcase
    end

    if (w_load) begin
      case (w_load_cmd)
        CMD_STATUS: w_tx_nxt = f_status_byte(r_ovf, w_cnt5);
        CMD_READ: begin
          if (!w_empty) begin
            w_tx_nxt = w_dout;
            w_pop    = 1'b1;
          end else begin
            w_tx_nxt = EMPTY_BYTE;
          end
        end
        CMD_CLEAR: begin
          w_tx_nxt = CLEAR_ACK;
          w_flush  = w_decode;
        end
        default: w_tx_nxt = BAD_CMD;
      endcase
    end else begin
      w_flush = 1'b0;
    end
  end

  // Overflow flag and registered MISO value
  always_comb begin
    w_miso_nxt = (w_state_nxt == S_RESP) ? w_tx_nxt[7] : 1'b0;
    if (w_flush) begin
      w_ovf_nxt = 1'b0;
    end else if (w_cap_rise && w_full && !w_pop) begin
      w_ovf_nxt = 1'b1;
    end else begin
      w_ovf_nxt = r_ovf;
    end
  end

  assign o_miso       = r_miso;
  assign o_fifo_count = w_count;
  assign o_overflow   = r_ovf;

endmodule

// File: tb/tb_cpu_trace_spi_ctrl.sv
// Scoreboard bench: stimulus queues expected bytes, a monitor compares each observation.
module tb_cpu_trace_spi_ctrl;

  localparam int HALF = 80;

  logic       clk = 1'b0;
  logic       i_reset_n;
  logic [7:0] i_instruction;
  logic       i_capturebyte;
  logic       i_spi_clk;
  logic       i_csn;
  logic       i_mosi;
  logic       o_miso;
  logic [4:0] o_fifo_count;
  logic       o_overflow;

  string      name_q[$];
  logic [7:0] val_q[$];
  int         n_vec = 0;
  int         n_bad = 0;
  string      obs_name;
  logic [7:0] obs_val;
  event       obs_ev;

  always #5 clk = ~clk;

  cpu_trace_spi_ctrl #(
    .DEPTH_LOG2  (4),
    .SYNC_STAGES (2)
  ) dut (
    .i_clk         (clk),
    .i_reset_n     (i_reset_n),
    .i_instruction (i_instruction),
    .i_capturebyte (i_capturebyte),
    .i_spi_clk     (i_spi_clk),
    .i_csn         (i_csn),
    .i_mosi        (i_mosi),
    .o_miso        (o_miso),
    .o_fifo_count  (o_fifo_count),
    .o_overflow    (o_overflow)
  );

  task automatic expect_val(input string n, input logic [7:0] v);
    name_q.push_back(n);
    val_q.push_back(v);
  endtask

  task automatic observe(input string n, input logic [7:0] v);
    obs_name = n;
    obs_val  = v;
    -> obs_ev;
    #0;
  endtask

  // Monitor: pop the oldest expectation for every observation.
  initial begin
    string      en;
    logic [7:0] ev;
    forever begin
      @(obs_ev);
      n_vec++;
      if (val_q.size() == 0) begin
        n_bad++;
        $display("FAIL %s: got %02h, nothing expected", obs_name, obs_val);
      end else begin
        en = name_q.pop_front();
        ev = val_q.pop_front();
        if (obs_val !== ev) begin
          n_bad++;
          $display("FAIL %s: got %02h, want %02h", en, obs_val, ev);
        end
      end
    end
  end

  task automatic capture(input logic [7:0] b);
    i_instruction = b;
    i_capturebyte = 1'b1;
    repeat (4) @(negedge clk);
    i_capturebyte = 1'b0;
    repeat (4) @(negedge clk);
  endtask

  task automatic check_regs(input string n, input logic [4:0] cnt, input logic ovf);
    expect_val(n, {ovf, 2'b00, cnt});
    @(negedge clk);
    observe(n, {o_overflow, 2'b00, o_fifo_count});
  endtask

  // Full transaction; the last SCK fall coincides with CS release.
  task automatic spi_xfer(input logic [7:0] cmd, input int nresp,
                          input bit cap_en, input logic [7:0] cap_val);
    logic [7:0] rx;
    i_csn = 1'b0;
    #(HALF);
    for (int b = 7; b >= 0; b--) begin
      i_mosi = cmd[b];
      #(HALF);
      i_spi_clk = 1'b1;
      if (b == 0 && cap_en) begin
        i_instruction = cap_val;
        i_capturebyte = 1'b1;
      end
      #(HALF);
      i_spi_clk = 1'b0;
      if (b == 0 && nresp == 0) i_csn = 1'b1;
    end
    i_mosi = 1'b0;
    for (int k = 0; k < nresp; k++) begin
      rx = 8'h00;
      for (int b = 7; b >= 0; b--) begin
        #(HALF);
        rx[b] = o_miso;
        i_spi_clk = 1'b1;
        #(HALF);
        i_spi_clk = 1'b0;
        if (k == nresp - 1 && b == 0) i_csn = 1'b1;
      end
      observe($sformatf("cmd%02h_resp%0d", cmd, k), rx);
    end
    i_capturebyte = 1'b0;
    #(4 * HALF);
  endtask

  task automatic spi_partial(input logic [7:0] cmd, input int nbits);
    i_csn = 1'b0;
    #(HALF);
    for (int b = 7; b > 7 - nbits; b--) begin
      i_mosi = cmd[b];
      #(HALF);
      i_spi_clk = 1'b1;
      #(HALF);
      i_spi_clk = 1'b0;
    end
    #(HALF);
    i_csn  = 1'b1;
    i_mosi = 1'b0;
    #(4 * HALF);
  endtask

  initial begin
    i_reset_n     = 1'b0;
    i_instruction = 8'h00;
    i_capturebyte = 1'b0;
    i_spi_clk     = 1'b0;
    i_csn         = 1'b1;
    i_mosi        = 1'b0;
    repeat (4) @(negedge clk);
    i_reset_n = 1'b1;
    @(negedge clk);

    // Reset with data in the FIFO
    capture(8'h11);
    capture(8'h22);
    check_regs("pre_reset_regs", 5'd2, 1'b0);
    i_reset_n = 1'b0;
    repeat (3) @(negedge clk);
    i_reset_n = 1'b1;
    check_regs("post_reset_regs", 5'd0, 1'b0);
    expect_val("post_reset_miso", 8'h00);
    observe("post_reset_miso", {7'b0, o_miso});

    // Status and read of three bytes
    capture(8'hA9);
    capture(8'h8D);
    capture(8'h4C);
    expect_val("status3", 8'h03);
    spi_xfer(8'h01, 1, 1'b0, 8'h00);
    expect_val("read_a9", 8'hA9);
    expect_val("read_8d", 8'h8D);
    expect_val("read_4c", 8'h4C);
    spi_xfer(8'h02, 3, 1'b0, 8'h00);
    check_regs("after_read3", 5'd0, 1'b0);

    // Overflow, clear
    for (int i = 0; i < 17; i++) capture(8'h30 + 8'(i));
    check_regs("full_ovf", 5'd16, 1'b1);
    expect_val("status_full", 8'h90);
    spi_xfer(8'h01, 1, 1'b0, 8'h00);
    expect_val("clear_ack", 8'hA5);
    spi_xfer(8'h03, 1, 1'b0, 8'h00);
    expect_val("status_cleared", 8'h00);
    spi_xfer(8'h01, 1, 1'b0, 8'h00);
    check_regs("after_clear", 5'd0, 1'b0);

    // Read on empty FIFO
    expect_val("empty_rd0", 8'h00);
    expect_val("empty_rd1", 8'h00);
    spi_xfer(8'h02, 2, 1'b0, 8'h00);
    check_regs("after_empty_rd", 5'd0, 1'b0);

    // Capture coincident with a pop while full
    for (int i = 0; i < 16; i++) capture(8'h10 + 8'(i));
    check_regs("full_again", 5'd16, 1'b0);
    expect_val("coinc_head", 8'h10);
    spi_xfer(8'h02, 1, 1'b1, 8'h55);
    check_regs("after_coinc", 5'd16, 1'b0);
    for (int i = 1; i < 16; i++) expect_val($sformatf("drain%0d", i), 8'h10 + 8'(i));
    expect_val("drain_55", 8'h55);
    spi_xfer(8'h02, 16, 1'b0, 8'h00);
    check_regs("after_drain", 5'd0, 1'b0);

    // Aborted command
    capture(8'h77);
    capture(8'h88);
    spi_partial(8'h02, 4);
    check_regs("after_abort", 5'd2, 1'b0);
    expect_val("status_abort", 8'h02);
    spi_xfer(8'h01, 1, 1'b0, 8'h00);
    expect_val("read_77", 8'h77);
    spi_xfer(8'h02, 1, 1'b0, 8'h00);
    check_regs("after_read77", 5'd1, 1'b0);

    // Unknown command
    expect_val("bad0", 8'hFF);
    expect_val("bad1", 8'hFF);
    spi_xfer(8'h5A, 2, 1'b0, 8'h00);

    #(1000);
    if (val_q.size() != 0) begin
      $display("FAIL unconsumed: got %0d leftover expectations, want 0", val_q.size());
      n_bad += val_q.size();
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
